pipelined_logic_unit: RTL and testbench

Parametrised, pipelined bitwise logic unit for the pipeline CPU's execute stage. It generalises the fixed 32-bit AND/NAND cell to WIDTH bits and eight selectable logic ops. It adds a zero flag, a configurable register depth, a valid/ready handshake with back-pressure, and a flush. It sits beside the adder in the ALU and presents the same carryout/overflow outputs (always 0) so the ALU result mux stays uniform.

---
 rtl/logic_unit_pkg.sv | 16 +
 rtl/logic_unit_stage.sv | 54 +++++
 rtl/pipelined_logic_unit.sv | 93 +++++++++
 tb/tb_pipelined_logic_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the execute-stage logic unit.
// Op codes are also used by the ALU decoder.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_NAND = 3'd1;
    localparam logic [OP_W-1:0] OP_OR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_ANDN = 3'd6;
    localparam logic [OP_W-1:0] OP_ORN  = 3'd7;

endpackage

// File: rtl/logic_unit_stage.sv
// One {valid, data} pipeline slot with valid/ready handshake.
// An empty slot accepts even when downstream is stalled.
module logic_unit_stage
    import logic_unit_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign ready_o = !valid_q || ready_i;
    assign load    = valid_i && ready_o && !flush_i;

    // Next state: flush kills, a new entry loads, a pop empties the slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; data only changes on a fresh entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipelined_logic_unit.sv
// Pipelined WIDTH-bit logic unit with zero flag and back-pressure.
// carryout/overflow are tied low so the ALU result mux stays uniform.
module pipelined_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carryout,
    output logic             overflow
);

    localparam int DW = WIDTH + 1;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [OP_W-1:0]  o,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (o)
            OP_AND:  r = x & y;
            OP_NAND: r = ~(x & y);
            OP_OR:   r = x | y;
            OP_NOR:  r = ~(x | y);
            OP_XOR:  r = x ^ y;
            OP_XNOR: r = ~(x ^ y);
            OP_ANDN: r = x & ~y;
            OP_ORN:  r = x | ~y;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] res_c;
    logic [DW-1:0]    entry;

    assign res_c = logic_op(op, a, b);
    assign entry = {(res_c == '0), res_c};

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic          vin, vout, rdy_up, rdy_dn;
        logic [DW-1:0] din, dout;

        if (k == 0) begin : g_head
            assign vin = in_valid;
            assign din = entry;
        end else begin : g_link
            assign vin = g_stg[k-1].vout;
            assign din = g_stg[k-1].dout;
        end

        if (k == STAGES - 1) begin : g_tail
            assign rdy_dn = out_ready;
        end else begin : g_mid
            assign rdy_dn = g_stg[k+1].rdy_up;
        end

        logic_unit_stage #(
            .W(DW)
        ) u_stage (
            .clk_i  (clk),
            .rst_i  (reset),
            .flush_i(flush),
            .valid_i(vin),
            .data_i (din),
            .ready_o(rdy_up),
            .valid_o(vout),
            .data_o (dout),
            .ready_i(rdy_dn)
        );
    end

    assign in_ready  = g_stg[0].rdy_up;
    assign out_valid = g_stg[STAGES-1].vout;
    assign result    = g_stg[STAGES-1].dout[WIDTH-1:0];
    assign zero      = g_stg[STAGES-1].dout[WIDTH];
    assign carryout  = 1'b0;
    assign overflow  = 1'b0;

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Bench for pipelined_logic_unit: directed scenarios plus random traffic
// checked against a queue-based model of an in-order STAGES-deep buffer.
module tb_pipelined_logic_unit;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst, flush, iv, ordy;
    logic        ir, ov, zf, co, ovf;
    logic [31:0] a, b, res;
    logic [2:0]  op;

    logic       v8;
    logic [7:0] a8, b8;
    logic [2:0] op8;
    logic       ir1, ov1, zf1, co1, ovf1;
    logic       ir4, ov4, zf4, co4, ovf4;
    logic [7:0] res1, res4;

    int checks = 0;
    int failures = 0;

    logic [32:0] q[$];
    logic        prev_stall;
    logic [32:0] prev_out;

    always #5 clk = ~clk;

    pipelined_logic_unit #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .reset(rst), .flush(flush),
        .in_valid(iv), .in_ready(ir),
        .a(a), .b(b), .op(op),
        .out_valid(ov), .out_ready(ordy),
        .result(res), .zero(zf),
        .carryout(co), .overflow(ovf)
    );

    pipelined_logic_unit #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .reset(rst), .flush(1'b0),
        .in_valid(v8), .in_ready(ir1),
        .a(a8), .b(b8), .op(op8),
        .out_valid(ov1), .out_ready(1'b1),
        .result(res1), .zero(zf1),
        .carryout(co1), .overflow(ovf1)
    );

    pipelined_logic_unit #(.WIDTH(8), .STAGES(4)) dut4 (
        .clk(clk), .reset(rst), .flush(1'b0),
        .in_valid(v8), .in_ready(ir4),
        .a(a8), .b(b8), .op(op8),
        .out_valid(ov4), .out_ready(1'b1),
        .result(res4), .zero(zf4),
        .carryout(co4), .overflow(ovf4)
    );

    function automatic logic [31:0] ref_op(
        input logic [2:0] o, input logic [31:0] x, input logic [31:0] y
    );
        case (o)
            3'd0: return x & y;
            3'd1: return ~(x & y);
            3'd2: return x | y;
            3'd3: return ~(x | y);
            3'd4: return x ^ y;
            3'd5: return ~(x ^ y);
            3'd6: return x & ~y;
            default: return x | ~y;
        endcase
    endfunction

    function automatic logic [32:0] ref_entry(
        input logic [2:0] o, input logic [31:0] x, input logic [31:0] y
    );
        logic [31:0] r;
        r = ref_op(o, x, y);
        return {(r == 32'd0), r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample/model before the edge, then step past the edge.
    task automatic tick();
        #1;
        chk("in_ready", 64'(ir), 64'(q.size() < S || ordy));
        chk("co_ovf", {62'd0, co, ovf}, 64'd0);
        chk("co_ovf_8", {60'd0, co1, ovf1, co4, ovf4}, 64'd0);
        if (prev_stall) begin
            chk("stall_valid", 64'(ov), 64'd1);
            chk("stall_stable", 64'({zf, res}), 64'(prev_out));
        end
        if (ov) begin
            chk("no_phantom", 64'(q.size() != 0), 64'd1);
            if (ordy && q.size() != 0) begin
                chk("order", 64'({zf, res}), 64'(q[0]));
                void'(q.pop_front());
            end
        end
        if (iv && ir && !flush) q.push_back(ref_entry(op, a, b));
        if (flush) q.delete();
        prev_stall = ov && !ordy && !flush;
        prev_out = {zf, res};
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tbl [8];
    logic [32:0] e;
    int acc;

    initial begin
        tbl[0] = 32'hF000_F000; tbl[1] = 32'h0FFF_0FFF;
        tbl[2] = 32'hFFF0_FFF0; tbl[3] = 32'h000F_000F;
        tbl[4] = 32'h0FF0_0FF0; tbl[5] = 32'hF00F_F00F;
        tbl[6] = 32'h00F0_00F0; tbl[7] = 32'hF0FF_F0FF;

        rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b1;
        a = '0; b = '0; op = '0;
        v8 = 1'b0; a8 = 8'hF0; b8 = 8'hCC; op8 = '0;
        prev_stall = 1'b0; prev_out = '0;
        #2;
        chk("rst_out", {31'd0, ov, res, zf}, 64'd0);
        chk("rst_in_ready", 64'({ir, ir1, ir4}), 64'h7);
        chk("rst_8bit", {46'd0, ov1, res1, ov4, res4}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Ops 0..7 back to back, one result per cycle.
        a = 32'hF0F0_F0F0; b = 32'hFF00_FF00;
        for (int c = 0; c < 10; c++) begin
            iv = (c < 8); op = 3'(c);
            tick();
            chk("seq_valid", 64'(ov), 64'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8)
                chk("seq_result", 64'(res), 64'(tbl[c-1]));
        end

        // Zero flag.
        a = 32'hAAAA_AAAA; b = 32'h5555_5555;
        iv = 1'b1; op = 3'd0; tick();
        op = 3'd2; tick();
        iv = 1'b0;
        chk("and_zero", {31'd0, ov, zf, res}, {31'd0, 1'b1, 1'b1, 32'd0});
        tick();
        chk("or_nonzero", {31'd0, ov, zf, res},
            {31'd0, 1'b1, 1'b0, 32'hFFFF_FFFF});
        tick();

        // Back-pressure: three pushes into a stalled unit.
        ordy = 1'b0; acc = 0;
        for (int c = 0; c < 3; c++) begin
            iv = 1'b1; op = 3'(c + 4);
            a = $urandom; b = $urandom;
            #1;
            if (ir) acc++;
            #0 tick();
        end
        iv = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd2);
        #1 chk("bp_full", 64'(ir), 64'd0);
        repeat (5) tick();
        ordy = 1'b1;
        repeat (4) tick();
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Flush with a same-cycle accept.
        ordy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            iv = 1'b1; op = 3'(c); a = $urandom; b = $urandom; tick();
        end
        ordy = 1'b1; flush = 1'b1; op = 3'd5; a = $urandom; tick();
        flush = 1'b0; iv = 1'b0;
        chk("flush_valid", 64'(ov), 64'd0);
        repeat (4) tick();

        // Asynchronous reset with two ops in flight.
        ordy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            iv = 1'b1; op = 3'd7; a = $urandom; b = $urandom; tick();
        end
        iv = 1'b0;
        chk("pre_rst_valid", 64'(ov), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst", {31'd0, ov, res, zf}, 64'd0);
        q.delete(); prev_stall = 1'b0;
        #1 rst = 1'b0;
        ordy = 1'b1;
        repeat (4) tick();

        // 8-bit instances, STAGES=1 and STAGES=4.
        for (int c = 0; c < 12; c++) begin
            v8 = (c < 8); op8 = 3'(c);
            tick();
            chk("s1_valid", 64'(ov1), 64'(c <= 7));
            if (c <= 7) begin
                e = ref_entry(3'(c), {24'd0, a8}, {24'd0, b8});
                chk("s1_result", 64'({zf1, res1}), 64'({e[32], e[7:0]}));
            end
            chk("s4_valid", 64'(ov4), 64'(c >= 3 && c <= 10));
            if (c >= 3 && c <= 10) begin
                e = ref_entry(3'(c - 3), {24'd0, a8}, {24'd0, b8});
                chk("s4_result", 64'({zf4, res4}), 64'({e[32], e[7:0]}));
            end
            chk("s8_in_ready", 64'({ir1, ir4}), 64'h3);
        end
        v8 = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            iv = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 15) == 0;
            op = 3'($urandom);
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            tick();
        end
        flush = 1'b0; iv = 1'b0; ordy = 1'b1;
        repeat (4) tick();
        chk("final_empty", 64'({ov, 1'b0} | 64'(q.size())), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
